// File: rtl/cic_rate_controller.sv
// CIC decimator sequencing: clear, settle and run control with
// integrator/comb clock enables, ratio reconfiguration and output handshake.
module cic_rate_controller #(
    parameter int RATIO_WIDTH   = 8,
    parameter int DEFAULT_RATIO = 2,
    parameter int M             = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   cfg_valid,
    input  logic [RATIO_WIDTH-1:0] cfg_ratio,
    output logic                   cfg_ready,
    input  logic                   in_valid,
    output logic                   int_ce,
    output logic                   comb_ce,
    output logic                   stage_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [RATIO_WIDTH-1:0] active_ratio,
    output logic                   busy
);

    localparam int SW = (M < 2) ? 1 : $clog2(M + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_in_valid_d;
    logic [RATIO_WIDTH-1:0] r_ratio;
    logic [RATIO_WIDTH-1:0] r_dec_cnt;
    logic [SW-1:0]          r_settle_cnt;
    logic                   r_out_valid;
    logic                   r_overflow;

    logic                   w_cfg_ready;
    logic                   w_active;
    logic                   w_cfg_hs;
    logic                   w_int_ce;
    logic                   w_last;
    logic                   w_comb_ce;
    logic                   w_settle_last;
    logic                   w_flush;
    logic                   w_run_strobe;

    assign w_cfg_hs      = cfg_valid & w_cfg_ready;
    assign w_int_ce      = r_in_valid_d & w_active;
    assign w_last        = (r_dec_cnt >= (r_ratio - RATIO_WIDTH'(1)));
    assign w_comb_ce     = w_int_ce & w_last;
    assign w_settle_last = (r_settle_cnt == SW'(M - 1));
    assign w_flush       = (w_next == S_IDLE) || (w_next == S_CLEAR);
    assign w_run_strobe  = w_comb_ce && (r_state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Dropping enable overrides every other transition.
    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_CLEAR;
                S_CLEAR:  w_next = S_SETTLE;
                S_SETTLE: begin
                    if (w_comb_ce && w_settle_last) begin
                        w_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_cfg_hs) begin
                        w_next = S_CLEAR;
                    end
                end
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cfg_ready = 1'b0;
        stage_clr   = 1'b0;
        busy        = 1'b0;
        w_active    = 1'b0;
        case (r_state)
            S_IDLE:   w_cfg_ready = 1'b1;
            S_CLEAR: begin
                stage_clr = 1'b1;
                busy      = 1'b1;
            end
            S_SETTLE: begin
                busy     = 1'b1;
                w_active = 1'b1;
            end
            S_RUN: begin
                w_cfg_ready = 1'b1;
                w_active    = 1'b1;
            end
            default: w_cfg_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_valid_d <= 1'b0;
            r_ratio      <= RATIO_WIDTH'(DEFAULT_RATIO);
        end else begin
            r_in_valid_d <= in_valid;
            if (w_cfg_hs) begin
                r_ratio <= (cfg_ratio == '0) ? RATIO_WIDTH'(1) : cfg_ratio;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_cnt    <= '0;
            r_settle_cnt <= '0;
        end else if (w_flush || (r_state == S_CLEAR)) begin
            r_dec_cnt    <= '0;
            r_settle_cnt <= '0;
        end else if (w_int_ce) begin
            r_dec_cnt <= w_last ? '0 : r_dec_cnt + RATIO_WIDTH'(1);
            if (w_comb_ce && (r_state == S_SETTLE)) begin
                r_settle_cnt <= r_settle_cnt + SW'(1);
            end
        end
    end

    // A strobe landing on an unaccepted output replaces it and flags the loss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_flush) begin
                r_out_valid <= 1'b0;
            end else if (w_run_strobe) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_cfg_hs || (w_next == S_CLEAR)) begin
                r_overflow <= 1'b0;
            end else if (w_run_strobe && r_out_valid && !out_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cfg_ready    = w_cfg_ready;
    assign int_ce       = w_int_ce;
    assign comb_ce      = w_comb_ce;
    assign out_valid    = r_out_valid;
    assign overflow     = r_overflow;
    assign active_ratio = r_ratio;

endmodule

// File: tb/tb_cic_rate_controller.sv
// Directed bench for cic_rate_controller with hand-derived cycle traces.
module tb_cic_rate_controller;

    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          cfg_valid;
    logic [RW-1:0] cfg_ratio;
    logic          cfg_ready;
    logic          in_valid;
    logic          int_ce;
    logic          comb_ce;
    logic          stage_clr;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic [RW-1:0] active_ratio;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cic_rate_controller #(
        .RATIO_WIDTH  (RW),
        .DEFAULT_RATIO(2),
        .M            (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ratio   (cfg_ratio),
        .cfg_ready   (cfg_ready),
        .in_valid    (in_valid),
        .int_ce      (int_ce),
        .comb_ce     (comb_ce),
        .stage_clr   (stage_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .active_ratio(active_ratio),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, stage_clr, int_ce, comb_ce, out_valid}
    function automatic logic [4:0] obs();
        return {busy, stage_clr, int_ce, comb_ce, out_valid};
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (obs() !== 5'b00000) begin
            bad++;
            $display("FAIL reset_flags: got %b want %b", obs(), 5'b00000);
        end
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
        end
        total++;
        if (active_ratio !== 8'd2) begin
            bad++;
            $display("FAIL reset_ratio: got %0d want 2", active_ratio);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_overflow: got %b want 0", overflow);
        end
        rst = 1'b0;
        tick();
        total++;
        if (obs() !== 5'b00000) begin
            bad++;
            $display("FAIL idle_hold: got %b want %b", obs(), 5'b00000);
        end
    endtask

    task automatic test_startup();
        logic [4:0] exp [10];
        exp = '{5'b11000, 5'b10100, 5'b10110, 5'b10100, 5'b10110,
                5'b00100, 5'b00110, 5'b00101, 5'b00110, 5'b00101};
        enable    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (obs() !== exp[i]) begin
                bad++;
                $display("FAIL startup_c%0d: got %b want %b", i, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_ratio_change();
        logic [4:0] e;
        cfg_valid = 1'b1;
        cfg_ratio = 8'd4;
        tick();
        cfg_valid = 1'b0;
        total++;
        if (obs() !== 5'b11000) begin
            bad++;
            $display("FAIL rc_clear: got %b want %b", obs(), 5'b11000);
        end
        total++;
        if (active_ratio !== 8'd4) begin
            bad++;
            $display("FAIL rc_ratio: got %0d want 4", active_ratio);
        end
        for (int k = 1; k <= 13; k++) begin
            tick();
            e = {k <= 8, 1'b0, 1'b1, (k % 4) == 0, k == 13};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL rc_c%0d: got %b want %b", k, obs(), e);
            end
            if (k == 1) begin
                total++;
                if (cfg_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL rc_settle_ready: got %b want 0", cfg_ready);
                end
            end
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if ({comb_ce, out_valid, overflow} !== 3'b110) begin
            bad++;
            $display("FAIL ovf_pre: got %b want 110",
                     {comb_ce, out_valid, overflow});
        end
        tick();
        total++;
        if ({out_valid, overflow} !== 2'b11) begin
            bad++;
            $display("FAIL ovf_set: got %b want 11", {out_valid, overflow});
        end
        enable = 1'b0;
        tick();
        total++;
        if (obs() !== 5'b00000) begin
            bad++;
            $display("FAIL ovf_idle_flags: got %b want %b", obs(), 5'b00000);
        end
        total++;
        if ({overflow, active_ratio} !== {1'b1, 8'd4}) begin
            bad++;
            $display("FAIL ovf_idle_retain: got %b/%0d want 1/4",
                     overflow, active_ratio);
        end
    endtask

    task automatic test_ratio_zero();
        logic [4:0] e;
        cfg_valid = 1'b1;
        cfg_ratio = 8'd0;
        tick();
        cfg_valid = 1'b0;
        total++;
        if ({overflow, active_ratio} !== {1'b0, 8'd1}) begin
            bad++;
            $display("FAIL rz_load: got %b/%0d want 0/1", overflow, active_ratio);
        end
        total++;
        if ({cfg_ready, obs()} !== 6'b100000) begin
            bad++;
            $display("FAIL rz_stay_idle: got %b want 100000", {cfg_ready, obs()});
        end
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        total++;
        if (obs() !== 5'b11000) begin
            bad++;
            $display("FAIL rz_clear: got %b want %b", obs(), 5'b11000);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            e = {k <= 2, 1'b0, 1'b1, 1'b1, k >= 4};
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL rz_c%0d: got %b want %b", k, obs(), e);
            end
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL rz_accept_no_ovf: got %b want 0", overflow);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (obs() !== 5'b00001) begin
            bad++;
            $display("FAIL rz_last_out: got %b want %b", obs(), 5'b00001);
        end
        tick();
        total++;
        if (obs() !== 5'b00000) begin
            bad++;
            $display("FAIL rz_drain: got %b want %b", obs(), 5'b00000);
        end
    endtask

    task automatic test_enable_drop_settle();
        logic [4:0] exp [7];
        logic       en  [7];
        exp = '{5'b00000, 5'b11000, 5'b10110, 5'b00000,
                5'b11000, 5'b10110, 5'b10110};
        en  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            enable = en[i];
            tick();
            total++;
            if (obs() !== exp[i]) begin
                bad++;
                $display("FAIL eds_c%0d: got %b want %b", i, obs(), exp[i]);
            end
        end
        tick();
        total++;
        if (obs() !== 5'b00110) begin
            bad++;
            $display("FAIL eds_run: got %b want %b", obs(), 5'b00110);
        end
    endtask

    task automatic test_async_reset();
        tick();
        total++;
        if (obs() !== 5'b00111) begin
            bad++;
            $display("FAIL ar_pre: got %b want %b", obs(), 5'b00111);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (obs() !== 5'b00000) begin
            bad++;
            $display("FAIL ar_flags: got %b want %b", obs(), 5'b00000);
        end
        total++;
        if ({cfg_ready, overflow, active_ratio} !== {1'b1, 1'b0, 8'd2}) begin
            bad++;
            $display("FAIL ar_regs: got %b/%b/%0d want 1/0/2",
                     cfg_ready, overflow, active_ratio);
        end
        #1;
        rst = 1'b0;
        tick();
        total++;
        if (obs() !== 5'b11000) begin
            bad++;
            $display("FAIL ar_release: got %b want %b", obs(), 5'b11000);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_ratio_change();
        test_overflow();
        test_ratio_zero();
        test_enable_drop_settle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_rate_controller.md
CIC_RATE_CONTROLLER -- requirements
Module: cic_rate_controller

Interface
REQ-001 Parameter RATIO_WIDTH, default 8, SHALL set the width of the decimation ratio field.
REQ-002 Parameter DEFAULT_RATIO, default 2, SHALL set the active ratio after reset.
REQ-003 Parameter M, default 2, SHALL set the number of decimated strobes discarded while the comb stages settle.
REQ-004 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 enable  in  1  SHALL be the run request; low forces IDLE.
REQ-007 cfg_valid  in  1  SHALL mark a ratio update request.
REQ-008 cfg_ratio  in  RATIO_WIDTH  SHALL carry the requested decimation ratio R.
REQ-009 cfg_ready  out  1  SHALL indicate that a ratio update can be accepted.
REQ-010 in_valid  in  1  SHALL mark a new input sample for the integrators.
REQ-011 int_ce  out  1  SHALL be the integrator clock enable.
REQ-012 comb_ce  out  1  SHALL be the comb-stage clock enable (decimated strobe).
REQ-013 stage_clr  out  1  SHALL be the synchronous clear for all integrator and comb registers.
REQ-014 out_valid  out  1  SHALL mark a valid decimated output.
REQ-015 out_ready  in  1  SHALL be the downstream accept.
REQ-016 overflow  out  1  SHALL be a sticky flag for a dropped decimated output.
REQ-017 active_ratio  out  RATIO_WIDTH  SHALL report the ratio currently in use.
REQ-018 busy  out  1  SHALL be high in CLEAR and SETTLE.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, SETTLE and RUN.
REQ-020 enable low SHALL force the next state to IDLE from any state, with priority over every other transition.
REQ-021 IDLE -> CLEAR SHALL occur when enable is high.
REQ-022 CLEAR SHALL last exactly one cycle with stage_clr=1, the decimation counter, settle counter and out_valid zeroed, then -> SETTLE.
REQ-023 cfg_ready SHALL be 1 in IDLE and RUN and 0 in CLEAR and SETTLE.
REQ-024 A handshake (cfg_valid & cfg_ready) SHALL load active_ratio, clear overflow, and, in RUN with enable high, transition to CLEAR.
REQ-025 A handshake in IDLE SHALL update active_ratio and leave the FSM in IDLE.
REQ-026 A cfg_ratio of 0 SHALL be loaded as 1.
REQ-027 In SETTLE and RUN, int_ce SHALL equal in_valid delayed by one register stage; in IDLE and CLEAR, int_ce SHALL be 0.
REQ-028 The decimation counter SHALL increment on each in_valid sample in SETTLE or RUN.
REQ-029 On the sample where the counter equals active_ratio-1, the counter SHALL wrap to 0 and comb_ce SHALL pulse, aligned in the same cycle as that sample's int_ce.
REQ-030 With R=1, comb_ce SHALL pulse for every sample.
REQ-031 In SETTLE, each comb_ce SHALL increment the settle counter.
REQ-032 The M-th comb_ce in SETTLE SHALL cause the transition to RUN.
REQ-033 comb_ce pulses in SETTLE SHALL NOT produce out_valid.
REQ-034 In RUN, out_valid SHALL set one cycle after comb_ce.
REQ-035 out_valid SHALL clear on out_ready when no new output arrives that cycle.
REQ-036 When a new output arrives while out_valid=1 and out_ready=0, overflow SHALL be set, out_valid SHALL stay 1, and the old output is considered lost.
REQ-037 When a new output arrives in the same cycle out_valid=1 and out_ready=1, out_valid SHALL stay 1 and overflow SHALL NOT be set.
REQ-038 overflow SHALL clear only on reset, CLEAR, or a cfg handshake.
REQ-039 Entry to IDLE SHALL drop out_valid, int_ce and comb_ce.
REQ-040 Entry to IDLE SHALL retain active_ratio and overflow.

Reset
REQ-041 On rst: state=IDLE, active_ratio=DEFAULT_RATIO, counters=0, int_ce=comb_ce=stage_clr=out_valid=overflow=busy=0, cfg_ready=1.
REQ-042 Reset asserted mid-operation SHALL take effect immediately, asynchronously.
REQ-043 Release of reset SHALL act on the first clk edge after deassertion.

Verification
REQ-044 Reset, enable=1, in_valid constant 1, R=2, M=2 -> stage_clr 1 cycle, comb_ce on every 2nd int_ce, first out_valid one cycle after the 3rd comb_ce.
REQ-045 In RUN at R=2, cfg handshake with cfg_ratio=4 -> CLEAR, 2 discarded strobes, then comb_ce every 4th sample, active_ratio=4.
REQ-046 out_ready held 0 across two RUN strobes -> overflow=1 and out_valid=1; a cfg handshake then clears overflow.
REQ-047 cfg_ratio=0 -> active_ratio=1, and comb_ce equals int_ce after settle.
REQ-048 enable dropped mid-SETTLE, then reasserted -> IDLE, then a fresh CLEAR, with the settle count restarting at 0.
REQ-049 rst pulsed asynchronously during RUN with out_valid=1 -> all outputs at reset values before the next clk edge.
